// File: rtl/rv_fetch_pkg.sv
// Shared fetch-stage types and constants.
package rv_fetch_pkg;

  localparam int unsigned PC_W    = 16;
  localparam int unsigned INSTR_W = 32;

  localparam logic [PC_W-1:0]    PC_STEP = 16'd4;
  localparam logic [INSTR_W-1:0] EBREAK  = 32'h00100073;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StHalted,
    StFault
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-side bus bundle: instruction-memory port plus the decode valid/ready slot.
// master = fetch unit, slave = memory/decode side.
interface instr_fetch_unit_if;
  import rv_fetch_pkg::*;

  logic [PC_W-1:0]    im_pc;
  logic [INSTR_W-1:0] im_instr;
  logic               if_valid;
  logic               if_ready;
  logic [INSTR_W-1:0] if_instr;
  logic [PC_W-1:0]    if_pc;

  modport master (
    output im_pc,
    input  im_instr,
    output if_valid,
    input  if_ready,
    output if_instr,
    output if_pc
  );

  modport slave (
    input  im_pc,
    output im_instr,
    input  if_valid,
    output if_ready,
    input  if_instr,
    input  if_pc
  );
endinterface

// File: rtl/fetch_slot_reg.sv
// One-entry valid/ready output register with flush; reusable by later pipeline stages.
module fetch_slot_reg #(
  parameter int unsigned InstrW = 32,
  parameter int unsigned PcW    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              flush,
  input  logic [InstrW-1:0] load_instr,
  input  logic [PcW-1:0]    load_pc,
  input  logic              ready,
  output logic              valid,
  output logic [InstrW-1:0] instr,
  output logic [PcW-1:0]    pc
);

  logic              valid_q;
  logic [InstrW-1:0] instr_q;
  logic [PcW-1:0]    pc_q;

  // Slot state: flush beats load, load beats drain-on-accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (load) begin
      valid_q <= 1'b1;
      instr_q <= load_instr;
      pc_q    <= load_pc;
    end else if (valid_q && ready) begin
      valid_q <= 1'b0;
    end
  end

  assign valid = valid_q;
  assign instr = instr_q;
  assign pc    = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches from a word-addressed ROM, and
// hands instructions to decode through a one-entry slot.
// Optional macro IF_ALIGN_CHECK_EN: misaligned redirect targets fault instead of
// being silently word-aligned.
module instr_fetch_unit
  import rv_fetch_pkg::*;
#(
  parameter logic [PC_W-1:0]    RESET_PC    = 16'h0000,
  parameter int unsigned        IMEM_BYTES  = 256,
  parameter logic [INSTR_W-1:0] EBREAK_WORD = EBREAK
) (
  input  logic                clk,
  input  logic                rst_n,
  instr_fetch_unit_if.master  bus,
  input  logic                redirect_valid,
  input  logic [PC_W-1:0]     redirect_pc,
  output logic                halted,
  output logic                fault,
  output logic [31:0]         fetch_count
);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     fetch_count_q;
  logic            load, flush, slot_free, in_range;

  assign bus.im_pc = pc_q;
  assign slot_free = !bus.if_valid || bus.if_ready;
  assign in_range  = 32'(pc_q) < IMEM_BYTES;

  // State, PC and accept counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      pc_q          <= RESET_PC;
      fetch_count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (bus.if_valid && bus.if_ready) begin
        fetch_count_q <= fetch_count_q + 32'd1;
      end
    end
  end

  // Next-state logic; redirect overrides every state.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    load    = 1'b0;
    flush   = 1'b0;
    if (redirect_valid) begin
      flush = 1'b1;
`ifdef IF_ALIGN_CHECK_EN
      pc_d = redirect_pc;
      if (redirect_pc[1:0] != 2'b00) begin
        state_d = StFault;
      end else begin
        state_d = StFetch;
      end
`else
      pc_d    = redirect_pc & ~PC_W'(3);
      state_d = StFetch;
`endif
    end else begin
      unique case (state_q)
        StIdle: state_d = StFetch;
        StFetch: begin
          if (slot_free) begin
            if (in_range) begin
              load = 1'b1;
              pc_d = pc_q + PC_STEP;
              if (bus.im_instr == EBREAK_WORD) begin
                state_d = StHalted;
              end
            end else begin
              flush   = 1'b1;
              state_d = StFault;
            end
          end
        end
        StHalted: state_d = StHalted;
        StFault:  state_d = StFault;
        default:  state_d = StIdle;
      endcase
    end
  end

  fetch_slot_reg #(
    .InstrW (INSTR_W),
    .PcW    (PC_W)
  ) u_slot (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .flush      (flush),
    .load_instr (bus.im_instr),
    .load_pc    (pc_q),
    .ready      (bus.if_ready),
    .valid      (bus.if_valid),
    .instr      (bus.if_instr),
    .pc         (bus.if_pc)
  );

  assign halted      = (state_q == StHalted);
  assign fault       = (state_q == StFault);
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit with an accepted-instruction scoreboard.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        halted;
  logic        fault;
  logic [31:0] fetch_count;

  instr_fetch_unit_if bus ();

  instr_fetch_unit u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halted         (halted),
    .fault          (fault),
    .fetch_count    (fetch_count)
  );

  int n_cmp = 0;
  int n_mis = 0;
  logic [31:0] rom [64];
  logic [15:0] sb_q [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model: same-cycle read, zero outside the array.
  always_comb begin
    bus.im_instr = 32'h0;
    if (bus.im_pc < 16'd256) bus.im_instr = rom[bus.im_pc[7:2]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_range(input logic [15:0] first, input logic [15:0] last);
    for (int a = int'(first); a <= int'(last); a += 4) sb_q.push_back(16'(a));
  endtask

  // Handshake seen mid-cycle is accepted at the next edge: pop and compare.
  always @(negedge clk) begin
    if (rst_n && bus.if_valid && bus.if_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected", {16'h0, bus.if_pc}, 32'hFFFF_FFFF);
      end else begin
        logic [15:0] epc;
        epc = sb_q.pop_front();
        check("sb_pc", {16'h0, bus.if_pc}, {16'h0, epc});
        check("sb_instr", bus.if_instr, rom[epc[7:2]]);
      end
    end
  end

  initial begin
    int guard;
    for (int i = 0; i < 64; i++) rom[i] = {12'(i), 5'd0, 3'd0, 5'd1, 7'h13};
    rom[0] = 32'h00300413;
    rom[1] = 32'h00100493;
    rom[2] = 32'h01000913;
    rom[3] = 32'h00100073;

    rst_n          = 1'b0;
    bus.if_ready   = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0;
    tick();
    tick();
    check("rst_valid", {31'h0, bus.if_valid}, 32'h0);
    check("rst_instr", bus.if_instr, 32'h0);
    check("rst_pc", {16'h0, bus.if_pc}, 32'h0);
    check("rst_halted", {31'h0, halted}, 32'h0);
    check("rst_fault", {31'h0, fault}, 32'h0);
    check("rst_count", fetch_count, 32'h0);
    check("rst_im_pc", {16'h0, bus.im_pc}, 32'h0);

    // Stream 0,4,8 then the EBREAK at 0xC.
    rst_n        = 1'b1;
    bus.if_ready = 1'b1;
    push_range(16'h0, 16'hC);
    tick();
    check("idle_valid", {31'h0, bus.if_valid}, 32'h0);
    tick();
    check("first_valid", {31'h0, bus.if_valid}, 32'h1);
    check("first_pc", {16'h0, bus.if_pc}, 32'h0);
    tick();
    check("second_pc", {16'h0, bus.if_pc}, 32'h4);
    tick();
    check("third_pc", {16'h0, bus.if_pc}, 32'h8);
    tick();
    check("ebreak_pc", {16'h0, bus.if_pc}, 32'hC);
    check("ebreak_halted", {31'h0, halted}, 32'h1);
    check("count3", fetch_count, 32'd3);
    tick();
    check("halt_drain_valid", {31'h0, bus.if_valid}, 32'h0);
    check("count4", fetch_count, 32'd4);
    tick();
    tick();
    check("halt_no_load", {31'h0, bus.if_valid}, 32'h0);
    check("halt_im_pc", {16'h0, bus.im_pc}, 32'h10);
    check("halt_held", {31'h0, halted}, 32'h1);

    // Redirect to 0 out of HALTED.
    bus.if_ready   = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0;
    tick();
    redirect_valid = 1'b0;
    check("redir_halted", {31'h0, halted}, 32'h0);
    check("redir_flush", {31'h0, bus.if_valid}, 32'h0);
    check("redir_im_pc", {16'h0, bus.im_pc}, 32'h0);
    push_range(16'h0, 16'h8);
    bus.if_ready = 1'b1;
    tick();
    check("resume_pc", {16'h0, bus.if_pc}, 32'h0);
    tick();
    check("bp_pc_start", {16'h0, bus.if_pc}, 32'h4);

    // Backpressure with PC 4 in the slot.
    bus.if_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_valid", {31'h0, bus.if_valid}, 32'h1);
      check("bp_pc", {16'h0, bus.if_pc}, 32'h4);
      check("bp_instr", bus.if_instr, 32'h00100493);
      check("bp_im_pc", {16'h0, bus.im_pc}, 32'h8);
      check("bp_count", fetch_count, 32'd5);
    end
    bus.if_ready = 1'b1;
    tick();
    check("bp_release_pc", {16'h0, bus.if_pc}, 32'h8);
    check("bp_release_count", fetch_count, 32'd6);

    // Redirect to 0x20 coincident with accepting PC 8.
    redirect_valid = 1'b1;
    redirect_pc    = 16'h20;
    tick();
    redirect_valid = 1'b0;
    check("redir_hs_count", fetch_count, 32'd7);
    check("redir_hs_valid", {31'h0, bus.if_valid}, 32'h0);
    push_range(16'h20, 16'hFC);
    tick();
    check("redir_target_valid", {31'h0, bus.if_valid}, 32'h1);
    check("redir_target_pc", {16'h0, bus.if_pc}, 32'h20);

    // Run off the end of the ROM.
    guard = 0;
    while (!fault && guard < 200) begin
      tick();
      guard++;
    end
    check("fault_timeout", {31'h0, fault}, 32'h1);
    check("fault_valid", {31'h0, bus.if_valid}, 32'h0);
    check("fault_im_pc", {16'h0, bus.im_pc}, 32'h100);
    check("fault_count", fetch_count, 32'd63);
    check("sb_drained", sb_q.size(), 32'd0);
    tick();
    check("fault_held", {31'h0, fault}, 32'h1);

    // Misaligned redirect target.
    bus.if_ready   = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 16'h22;
    tick();
    redirect_valid = 1'b0;
`ifdef IF_ALIGN_CHECK_EN
    check("align_fault", {31'h0, fault}, 32'h1);
    check("align_im_pc", {16'h0, bus.im_pc}, 32'h22);
    tick();
    check("align_no_issue", {31'h0, bus.if_valid}, 32'h0);
`else
    check("align_fault", {31'h0, fault}, 32'h0);
    check("align_im_pc", {16'h0, bus.im_pc}, 32'h20);
    tick();
    check("align_valid", {31'h0, bus.if_valid}, 32'h1);
    check("align_pc", {16'h0, bus.if_pc}, 32'h20);
`endif

    // Reset beats a simultaneous redirect while stalled.
    rst_n          = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 16'h40;
    tick();
    redirect_valid = 1'b0;
    check("rst2_valid", {31'h0, bus.if_valid}, 32'h0);
    check("rst2_im_pc", {16'h0, bus.im_pc}, 32'h0);
    check("rst2_count", fetch_count, 32'h0);
    check("rst2_fault", {31'h0, fault}, 32'h0);
    check("rst2_pc", {16'h0, bus.if_pc}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
